trigger_phase_scan: RTL and testbench

TRIGGER_PHASE_SCAN -- requirements
Module: trigger_phase_scan

---
 rtl/trigger_phase_scan_if.sv | 29 ++
 rtl/trigger_phase_scan.sv | 252 +++++++++++++++++++++++++
 tb/tb_trigger_phase_scan.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trigger_phase_scan_if.sv
// Signal bundle between the trigger phase-scan controller and its environment.
// The controller is the slave: it takes the control/sampler inputs and drives
// the test pulse and the per-step report.
interface trigger_phase_scan_if;
  logic       start;
  logic       abort;
  logic [7:0] repeat_n;
  logic [2:0] width;
  logic       frame;
  logic       test_trig;
  logic       res_valid;
  logic [3:0] res_pos;
  logic       busy;
  logic       step_valid;
  logic [3:0] step_phase;
  logic [7:0] step_hits;
  logic [7:0] step_miss;
  logic       done;

  modport master (
    output start, abort, repeat_n, width, frame, res_valid, res_pos,
    input  test_trig, busy, step_valid, step_phase, step_hits, step_miss, done
  );

  modport slave (
    input  start, abort, repeat_n, width, frame, res_valid, res_pos,
    output test_trig, busy, step_valid, step_phase, step_hits, step_miss, done
  );
endinterface

// File: rtl/trigger_phase_scan.sv
// Trigger phase scan: steps a test pulse through every 400 MHz phase of the
// frame, fires it repeat_n times per phase, checks the sampler's reported
// position against the expected one and reports hits/misses per phase.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for start
// WAIT_FRAME | waiting for the frame pulse that anchors the next test pulse
// DELAY      | counting down the phase offset after the frame
// PULSE      | test_trig high for the latched width
// WAIT_RES   | waiting for the sampler result or the timeout
// GAP        | letting GAP_FRAMES frames pass before the next test pulse
// REPORT     | one-cycle step report
// DONE       | one-cycle scan-complete pulse
module trigger_phase_scan #(
  parameter int PHASE_MAX  = 9,
  parameter int EXP_OFS    = 0,
  parameter int TIMEOUT    = 63,
  parameter int GAP_FRAMES = 4
) (
  input  logic                 clk400,
  input  logic                 reset,
  trigger_phase_scan_if.slave  bus
);

  localparam int FRAME_LEN = PHASE_MAX + 1;
  localparam int OFS_RED   = EXP_OFS % FRAME_LEN;
  localparam int TW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int GW        = (GAP_FRAMES < 2) ? 1 : $clog2(GAP_FRAMES);

  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_FRAMES - 1);
  localparam logic [3:0]    PHASE_LAST = 4'(PHASE_MAX);
  localparam logic [4:0]    FRAME_L5   = 5'(FRAME_LEN);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FRAME = 3'd1,
    DELAY      = 3'd2,
    PULSE      = 3'd3,
    WAIT_RES   = 3'd4,
    GAP        = 3'd5,
    REPORT     = 3'd6,
    DONE       = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      phase_q, phase_d;
  logic [7:0]      rep_q, rep_d;
  logic [7:0]      hits_q, hits_d;
  logic [7:0]      miss_q, miss_d;
  logic [7:0]      rep_n_q, rep_n_d;
  logic [2:0]      width_q, width_d;
  logic [3:0]      dly_q, dly_d;
  logic [2:0]      wcnt_q, wcnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            trig_q, trig_d;
  logic            step_valid_q, step_valid_d;
  logic            done_q, done_d;
  logic [3:0]      step_phase_q, step_phase_d;
  logic [7:0]      step_hits_q, step_hits_d;
  logic [7:0]      step_miss_q, step_miss_d;

  logic [4:0]      exp_sum;
  logic [3:0]      exp_pos;
  logic [8:0]      rep_next;

  // Expected sampler position for the current phase, wrapped into the frame
  // without a divider (phase and reduced offset are both below FRAME_LEN).
  always_comb begin
    exp_sum = {1'b0, phase_q} + 5'(OFS_RED);
    exp_pos = (exp_sum >= FRAME_L5) ? 4'(exp_sum - FRAME_L5) : exp_sum[3:0];
  end

  assign rep_next = {1'b0, rep_q} + 9'd1;

  // Next-state logic plus next values of every counter and registered output.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    rep_d        = rep_q;
    hits_d       = hits_q;
    miss_d       = miss_q;
    rep_n_d      = rep_n_q;
    width_d      = width_q;
    dly_d        = dly_q;
    wcnt_d       = wcnt_q;
    tmo_d        = tmo_q;
    gap_d        = gap_q;
    step_phase_d = step_phase_q;
    step_hits_d  = step_hits_q;
    step_miss_d  = step_miss_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          rep_n_d = (bus.repeat_n == 8'd0) ? 8'd1 : bus.repeat_n;
          width_d = (bus.width == 3'd0) ? 3'd1 : bus.width;
          phase_d = 4'd0;
          rep_d   = 8'd0;
          hits_d  = 8'd0;
          miss_d  = 8'd0;
          state_d = WAIT_FRAME;
        end
      end

      WAIT_FRAME: begin
        if (bus.frame) begin
          // Phase 0 pulses right after the frame, so DELAY is skipped.
          if (phase_q == 4'd0) begin
            wcnt_d  = width_q;
            state_d = PULSE;
          end else begin
            dly_d   = phase_q;
            state_d = DELAY;
          end
        end
      end

      DELAY: begin
        // Leaving as the counter steps to zero puts the first pulse cycle
        // exactly phase+1 cycles after the frame cycle.
        dly_d = dly_q - 4'd1;
        if (dly_q == 4'd1) begin
          wcnt_d  = width_q;
          state_d = PULSE;
        end
      end

      PULSE: begin
        wcnt_d = wcnt_q - 3'd1;
        if (wcnt_q == 3'd1) begin
          tmo_d   = '0;
          state_d = WAIT_RES;
        end
      end

      WAIT_RES: begin
        // A result in the expiry cycle wins over the timeout.
        if (bus.res_valid) begin
          if (bus.res_pos == exp_pos) hits_d = hits_q + 8'd1;
          else                        miss_d = miss_q + 8'd1;
          gap_d   = '0;
          state_d = GAP;
        end else if (tmo_q == TMO_LAST) begin
          miss_d  = miss_q + 8'd1;
          gap_d   = '0;
          state_d = GAP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      GAP: begin
        if (bus.frame) begin
          if (gap_q == GAP_LAST) begin
            rep_d   = rep_next[7:0];
            state_d = (rep_next < {1'b0, rep_n_q}) ? WAIT_FRAME : REPORT;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end

      REPORT: begin
        if (phase_q == PHASE_LAST) begin
          state_d = DONE;
        end else begin
          phase_d = phase_q + 4'd1;
          rep_d   = 8'd0;
          hits_d  = 8'd0;
          miss_d  = 8'd0;
          state_d = WAIT_FRAME;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end

    // Report fields are captured on entry to REPORT and held afterwards.
    if ((state_d == REPORT) && (state_q != REPORT)) begin
      step_phase_d = phase_q;
      step_hits_d  = hits_q;
      step_miss_d  = miss_q;
    end

    trig_d       = (state_d == PULSE);
    step_valid_d = (state_d == REPORT);
    done_d       = (state_d == DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk400 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      phase_q      <= 4'd0;
      rep_q        <= 8'd0;
      hits_q       <= 8'd0;
      miss_q       <= 8'd0;
      rep_n_q      <= 8'd0;
      width_q      <= 3'd0;
      dly_q        <= 4'd0;
      wcnt_q       <= 3'd0;
      tmo_q        <= '0;
      gap_q        <= '0;
      trig_q       <= 1'b0;
      step_valid_q <= 1'b0;
      done_q       <= 1'b0;
      step_phase_q <= 4'd0;
      step_hits_q  <= 8'd0;
      step_miss_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      rep_q        <= rep_d;
      hits_q       <= hits_d;
      miss_q       <= miss_d;
      rep_n_q      <= rep_n_d;
      width_q      <= width_d;
      dly_q        <= dly_d;
      wcnt_q       <= wcnt_d;
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
      trig_q       <= trig_d;
      step_valid_q <= step_valid_d;
      done_q       <= done_d;
      step_phase_q <= step_phase_d;
      step_hits_q  <= step_hits_d;
      step_miss_q  <= step_miss_d;
    end
  end

  assign bus.test_trig  = trig_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.step_valid = step_valid_q;
  assign bus.step_phase = step_phase_q;
  assign bus.step_hits  = step_hits_q;
  assign bus.step_miss  = step_miss_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_trigger_phase_scan.sv
// Directed bench for trigger_phase_scan: free-running 10-cycle frame source,
// a scripted sampler responder, and one task per scenario.
`timescale 1ns/1ps
module tb_trigger_phase_scan;

  logic clk400 = 1'b0;
  logic reset;

  trigger_phase_scan_if bus();

  trigger_phase_scan #(
    .PHASE_MAX(9), .EXP_OFS(0), .TIMEOUT(63), .GAP_FRAMES(4)
  ) dut (
    .clk400(clk400),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk400 = ~clk400;

  int errors = 0;
  int checks = 0;

  // monitor / responder state
  int frame_pos;
  bit trig_prev;
  int run_len;
  int rise_ofs[$];
  int widths[$];
  int rep_phase[$];
  int rep_hits[$];
  int rep_miss[$];
  int done_cnt;
  int rise_cnt;
  int pulse_idx;
  int resp_mode;   // 0 none, 1 echo phase, 2 wrong on even reps
  int resp_delay;
  int resp_reps;
  int resp_cnt;
  int mph, mrp;
  logic [3:0] pending_pos;

  // Frame source, output monitor and sampler responder, all on the falling edge.
  initial begin
    frame_pos = 9; trig_prev = 0; run_len = 0; done_cnt = 0; rise_cnt = 0;
    pulse_idx = 0; resp_mode = 0; resp_delay = 5; resp_reps = 1; resp_cnt = -1;
    pending_pos = 4'd0;
    bus.frame = 1'b0; bus.res_valid = 1'b0; bus.res_pos = 4'd0;
    forever begin
      @(negedge clk400);
      frame_pos = (frame_pos == 9) ? 0 : frame_pos + 1;
      bus.frame = (frame_pos == 0);
      if (bus.test_trig && !trig_prev) begin
        rise_ofs.push_back(frame_pos);
        rise_cnt++;
        run_len = 1;
      end else if (bus.test_trig) begin
        run_len++;
      end
      if (!bus.test_trig && trig_prev) begin
        widths.push_back(run_len);
        mph = pulse_idx / resp_reps;
        mrp = pulse_idx % resp_reps;
        pulse_idx++;
        if (resp_mode == 1) begin
          pending_pos = 4'(mph % 10);
          resp_cnt = resp_delay;
        end else if (resp_mode == 2) begin
          pending_pos = (mrp % 2 == 0) ? 4'((mph + 1) % 10) : 4'(mph % 10);
          resp_cnt = resp_delay;
        end
      end
      trig_prev = bus.test_trig;
      if (bus.step_valid) begin
        rep_phase.push_back(int'(bus.step_phase));
        rep_hits.push_back(int'(bus.step_hits));
        rep_miss.push_back(int'(bus.step_miss));
      end
      if (bus.done) done_cnt++;
      bus.res_valid = 1'b0;
      if (resp_cnt == 0) begin
        bus.res_valid = 1'b1;
        bus.res_pos = pending_pos;
        resp_cnt = -1;
      end else if (resp_cnt > 0) begin
        resp_cnt--;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic clear_mon(input int mode, input int dly, input int reps);
    @(posedge clk400);
    rise_ofs.delete(); widths.delete();
    rep_phase.delete(); rep_hits.delete(); rep_miss.delete();
    done_cnt = 0; rise_cnt = 0; pulse_idx = 0; resp_cnt = -1;
    resp_mode = mode; resp_delay = dly; resp_reps = reps;
  endtask

  task automatic pulse_start(input logic [7:0] rn, input logic [2:0] w);
    @(negedge clk400);
    bus.repeat_n = rn; bus.width = w; bus.start = 1'b1;
    @(negedge clk400);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk400);
      if (done_cnt >= 1) begin ok = 1; break; end
    end
    repeat (4) @(negedge clk400);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.repeat_n = 8'd0; bus.width = 3'd0;
    repeat (3) @(negedge clk400);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.test_trig !== 1'b0) begin errors++; $display("FAIL reset_trig: got %b expected 0", bus.test_trig); end
    checks++; if (bus.step_valid !== 1'b0) begin errors++; $display("FAIL reset_step_valid: got %b expected 0", bus.step_valid); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.step_phase !== 4'd0) begin errors++; $display("FAIL reset_step_phase: got %0d expected 0", bus.step_phase); end
    checks++; if (bus.step_hits !== 8'd0) begin errors++; $display("FAIL reset_step_hits: got %0d expected 0", bus.step_hits); end
    checks++; if (bus.step_miss !== 8'd0) begin errors++; $display("FAIL reset_step_miss: got %0d expected 0", bus.step_miss); end
    reset = 1'b0;
    repeat (3) @(negedge clk400);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_basic_scan();
    bit ok;
    clear_mon(1, 5, 1);
    pulse_start(8'd1, 3'd2);
    wait_done(3000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_done_seen: got %b expected 1", ok); end
    checks++; if (rep_phase.size() !== 10) begin errors++; $display("FAIL basic_reports: got %0d expected 10", rep_phase.size()); end
    checks++; if (widths.size() !== 10) begin errors++; $display("FAIL basic_pulses: got %0d expected 10", widths.size()); end
    for (int i = 0; i < 10; i++) begin
      int p, h, m, w, r;
      p = (i < rep_phase.size()) ? rep_phase[i] : -1;
      h = (i < rep_hits.size()) ? rep_hits[i] : -1;
      m = (i < rep_miss.size()) ? rep_miss[i] : -1;
      w = (i < widths.size()) ? widths[i] : -1;
      r = (i < rise_ofs.size()) ? rise_ofs[i] : -1;
      checks++; if (p !== i) begin errors++; $display("FAIL basic_phase[%0d]: got %0d expected %0d", i, p, i); end
      checks++; if (h !== 1) begin errors++; $display("FAIL basic_hits[%0d]: got %0d expected 1", i, h); end
      checks++; if (m !== 0) begin errors++; $display("FAIL basic_miss[%0d]: got %0d expected 0", i, m); end
      checks++; if (w !== 2) begin errors++; $display("FAIL basic_width[%0d]: got %0d expected 2", i, w); end
      checks++; if (r !== (i + 1) % 10) begin errors++; $display("FAIL basic_rise[%0d]: got %0d expected %0d", i, r, (i + 1) % 10); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_cycles: got %0d expected 1", done_cnt); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", bus.busy); end
    checks++; if (bus.step_phase !== 4'd9) begin errors++; $display("FAIL basic_hold_phase: got %0d expected 9", bus.step_phase); end
    checks++; if (bus.step_hits !== 8'd1) begin errors++; $display("FAIL basic_hold_hits: got %0d expected 1", bus.step_hits); end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_mon(0, 0, 3);
    pulse_start(8'd3, 3'd2);
    wait_done(9000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tmo_done_seen: got %b expected 1", ok); end
    checks++; if (widths.size() !== 30) begin errors++; $display("FAIL tmo_pulses: got %0d expected 30", widths.size()); end
    for (int i = 0; i < 10; i++) begin
      int h, m;
      h = (i < rep_hits.size()) ? rep_hits[i] : -1;
      m = (i < rep_miss.size()) ? rep_miss[i] : -1;
      checks++; if (h !== 0) begin errors++; $display("FAIL tmo_hits[%0d]: got %0d expected 0", i, h); end
      checks++; if (m !== 3) begin errors++; $display("FAIL tmo_miss[%0d]: got %0d expected 3", i, m); end
    end
  endtask

  task automatic test_mixed();
    bit ok;
    clear_mon(2, 5, 4);
    pulse_start(8'd4, 3'd2);
    wait_done(7000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mixed_done_seen: got %b expected 1", ok); end
    for (int i = 0; i < 10; i++) begin
      int p, h, m;
      p = (i < rep_phase.size()) ? rep_phase[i] : -1;
      h = (i < rep_hits.size()) ? rep_hits[i] : -1;
      m = (i < rep_miss.size()) ? rep_miss[i] : -1;
      checks++; if (p !== i) begin errors++; $display("FAIL mixed_phase[%0d]: got %0d expected %0d", i, p, i); end
      checks++; if (h !== 2) begin errors++; $display("FAIL mixed_hits[%0d]: got %0d expected 2", i, h); end
      checks++; if (m !== 2) begin errors++; $display("FAIL mixed_miss[%0d]: got %0d expected 2", i, m); end
    end
  endtask

  task automatic test_timeout_edge();
    bit ok;
    // result in the last WAIT_RES cycle: counted as a hit
    clear_mon(1, 62, 1);
    pulse_start(8'd1, 3'd1);
    wait_done(4000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL edge_done_seen: got %b expected 1", ok); end
    for (int i = 0; i < 10; i++) begin
      int h, m;
      h = (i < rep_hits.size()) ? rep_hits[i] : -1;
      m = (i < rep_miss.size()) ? rep_miss[i] : -1;
      checks++; if (h !== 1) begin errors++; $display("FAIL edge_hits[%0d]: got %0d expected 1", i, h); end
      checks++; if (m !== 0) begin errors++; $display("FAIL edge_miss[%0d]: got %0d expected 0", i, m); end
    end
    // one cycle later the timeout has already fired and the result is ignored
    clear_mon(1, 63, 1);
    pulse_start(8'd1, 3'd1);
    wait_done(4000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL late_done_seen: got %b expected 1", ok); end
    for (int i = 0; i < 10; i++) begin
      int h, m;
      h = (i < rep_hits.size()) ? rep_hits[i] : -1;
      m = (i < rep_miss.size()) ? rep_miss[i] : -1;
      checks++; if (h !== 0) begin errors++; $display("FAIL late_hits[%0d]: got %0d expected 0", i, h); end
      checks++; if (m !== 1) begin errors++; $display("FAIL late_miss[%0d]: got %0d expected 1", i, m); end
    end
  endtask

  task automatic test_abort();
    bit prev_t;
    int rises;
    bit hit;
    clear_mon(1, 5, 1);
    pulse_start(8'd1, 3'd2);
    prev_t = 0; rises = 0; hit = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk400);
      if (bus.test_trig && !prev_t) rises++;
      prev_t = bus.test_trig;
      if (rises == 4) begin hit = 1; break; end
    end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL abort_reach_phase3: got %b expected 1", hit); end
    bus.abort = 1'b1;
    @(negedge clk400);
    bus.abort = 1'b0;
    checks++; if (bus.test_trig !== 1'b0) begin errors++; $display("FAIL abort_trig: got %b expected 0", bus.test_trig); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.step_valid !== 1'b0) begin errors++; $display("FAIL abort_step_valid: got %b expected 0", bus.step_valid); end
    repeat (200) @(negedge clk400);
    checks++; if (rep_phase.size() !== 3) begin errors++; $display("FAIL abort_report_count: got %0d expected 3", rep_phase.size()); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_done: got %0d expected 0", done_cnt); end
    // restart scans from phase 0
    clear_mon(1, 5, 1);
    pulse_start(8'd1, 3'd2);
    hit = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk400);
      if (rep_phase.size() >= 1) begin hit = 1; break; end
    end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL restart_report_seen: got %b expected 1", hit); end
    checks++; if (bus.step_phase !== 4'd0) begin errors++; $display("FAIL restart_phase: got %0d expected 0", bus.step_phase); end
    bus.abort = 1'b1;
    @(negedge clk400);
    bus.abort = 1'b0;
    repeat (80) @(negedge clk400);
  endtask

  task automatic test_zero_and_restart();
    bit ok;
    clear_mon(1, 5, 1);
    pulse_start(8'd0, 3'd0);
    repeat (30) @(negedge clk400);
    pulse_start(8'd5, 3'd3);
    wait_done(3000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL zero_done_seen: got %b expected 1", ok); end
    checks++; if (rep_phase.size() !== 10) begin errors++; $display("FAIL zero_reports: got %0d expected 10", rep_phase.size()); end
    for (int i = 0; i < 10; i++) begin
      int p, h, m, w, r;
      p = (i < rep_phase.size()) ? rep_phase[i] : -1;
      h = (i < rep_hits.size()) ? rep_hits[i] : -1;
      m = (i < rep_miss.size()) ? rep_miss[i] : -1;
      w = (i < widths.size()) ? widths[i] : -1;
      r = (i < rise_ofs.size()) ? rise_ofs[i] : -1;
      checks++; if (p !== i) begin errors++; $display("FAIL zero_phase[%0d]: got %0d expected %0d", i, p, i); end
      checks++; if (h !== 1) begin errors++; $display("FAIL zero_hits[%0d]: got %0d expected 1", i, h); end
      checks++; if (m !== 0) begin errors++; $display("FAIL zero_miss[%0d]: got %0d expected 0", i, m); end
      checks++; if (w !== 1) begin errors++; $display("FAIL zero_width[%0d]: got %0d expected 1", i, w); end
      checks++; if (r !== (i + 1) % 10) begin errors++; $display("FAIL zero_rise[%0d]: got %0d expected %0d", i, r, (i + 1) % 10); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_cycles: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    bit hit;
    clear_mon(1, 5, 1);
    pulse_start(8'd1, 3'd2);
    hit = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk400);
      if (rep_phase.size() >= 2) begin hit = 1; break; end
    end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL rstmid_reports_seen: got %b expected 1", hit); end
    repeat (7) @(negedge clk400);
    reset = 1'b1;
    @(negedge clk400);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.step_phase !== 4'd0) begin errors++; $display("FAIL rstmid_step_phase: got %0d expected 0", bus.step_phase); end
    checks++; if (bus.step_hits !== 8'd0) begin errors++; $display("FAIL rstmid_step_hits: got %0d expected 0", bus.step_hits); end
    reset = 1'b0;
    bus.repeat_n = 8'd1; bus.width = 3'd1; bus.start = 1'b1;
    @(negedge clk400);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_start_accept: got %b expected 1", bus.busy); end
    bus.abort = 1'b1;
    @(negedge clk400);
    bus.abort = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_abort_busy: got %b expected 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_timeout();
    test_mixed();
    test_timeout_edge();
    test_abort();
    test_zero_and_restart();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
